// File: rtl/muldiv_iter.sv
// Iterative MUL/DIV/DIVU/REM/REMU on one shared shift/add datapath, 64- and 32-bit word modes.
// Define MULDIV_EARLY_OUT_EN to let short multiplies and small-dividend divides finish early.
module muldiv_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            data_ok,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU} op_t;

  function automatic logic [XLEN-1:0] sext_w(input logic [H-1:0] v);
    return {{H{v[H-1]}}, v};
  endfunction

  state_t          state, state_nxt;
  op_t             op_in;
  logic [XLEN-1:0] acc, dsr, quo;
  logic [CW-1:0]   cnt;
  logic            is_mul, is_rem, is_word, negate;

  // Acceptance-time decode: operand extension, magnitudes and the cases resolved without iterating.
  logic            op_legal, in_mul, in_rem, in_signed, sign_a, sign_b;
  logic            div_zero, div_ovf, div_small, special, accept, finish;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, dividend, min_val, special_val;

  assign op_in = op_t'(op);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    op_legal  = (op <= 3'd4);
    in_mul    = (op_in == OP_MUL);
    in_rem    = (op_in == OP_REM) || (op_in == OP_REMU);
    in_signed = (op_in == OP_DIV) || (op_in == OP_REM);
    a_ext     = a;
    b_ext     = b;
    if (word) begin
      a_ext = in_signed ? sext_w(a[H-1:0]) : {{H{1'b0}}, a[H-1:0]};
      b_ext = in_signed ? sext_w(b[H-1:0]) : {{H{1'b0}}, b[H-1:0]};
    end
    sign_a   = in_signed & a_ext[XLEN-1];
    sign_b   = in_signed & b_ext[XLEN-1];
    mag_a    = sign_a ? -a_ext : a_ext;
    mag_b    = sign_b ? -b_ext : b_ext;
    dividend = word ? sext_w(a[H-1:0]) : a;
    min_val  = word ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    div_ovf  = in_signed && (a_ext == min_val) && (b_ext == '1);
`ifdef MULDIV_EARLY_OUT_EN
    div_small = (mag_a < mag_b);
`else
    div_small = 1'b0;
`endif
    if (div_zero)     special_val = in_rem ? dividend : '1;
    else if (div_ovf) special_val = in_rem ? '0 : dividend;
    else              special_val = in_rem ? dividend : '0;
    special = !in_mul && (div_zero || div_ovf || div_small);
    accept  = (state == IDLE) && valid && op_legal;
  end

  // One iteration: shift-add for MUL, restoring subtract on magnitudes for the divides.
  logic [XLEN:0]   rem_shift, rem_diff;
  logic            rem_ge;
  logic [XLEN-1:0] acc_nxt, dsr_nxt, quo_nxt, raw, fixed, final_val;

  always_comb begin
    rem_shift = {acc, quo[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, dsr};
    rem_ge    = !rem_diff[XLEN];
    if (is_mul) begin
      acc_nxt = acc + (quo[0] ? dsr : '0);
      dsr_nxt = dsr << 1;
      quo_nxt = quo >> 1;
    end else begin
      acc_nxt = rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      dsr_nxt = dsr;
      quo_nxt = {quo[XLEN-2:0], rem_ge};
    end
    raw       = (is_mul || is_rem) ? acc_nxt : quo_nxt;
    fixed     = negate ? -raw : raw;
    final_val = is_word ? sext_w(fixed[H-1:0]) : fixed;
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign finish = (cnt == CW'(1)) || (is_mul && (quo == '0));
`else
  assign finish = (cnt == CW'(1));
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : BUSY;
      BUSY:    if (!valid) state_nxt = IDLE;
               else if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      dsr     <= '0;
      quo     <= '0;
      cnt     <= '0;
      is_mul  <= 1'b0;
      is_rem  <= 1'b0;
      is_word <= 1'b0;
      negate  <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      acc     <= '0;
      dsr     <= in_mul ? a_ext : mag_b;
      // Word divides start with the 32-bit dividend at the top so 32 shifts consume it.
      quo     <= in_mul ? b_ext : (word ? (mag_a << H) : mag_a);
      cnt     <= word ? CW'(H) : CW'(XLEN);
      is_mul  <= in_mul;
      is_rem  <= in_rem;
      is_word <= word;
      negate  <= in_rem ? sign_a : (sign_a ^ sign_b);
      if (special) result <= special_val;
    end else if ((state == BUSY) && valid) begin
      acc <= acc_nxt;
      dsr <= dsr_nxt;
      quo <= quo_nxt;
      cnt <= cnt - CW'(1);
      if (finish) result <= final_val;
    end
  end

  assign data_ok = (state == DONE);
  assign busy    = (state == BUSY);

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: expected results queued at request time, popped on data_ok.
module tb_muldiv_iter;
  localparam logic [2:0] MUL = 3'd0, DIV = 3'd1, DIVU = 3'd2, REM = 3'd3, REMU = 3'd4;

  logic        clk = 1'b0, resetn = 1'b0, valid = 1'b0, word = 1'b0;
  logic [2:0]  op = '0;
  logic [63:0] a = '0, b = '0;
  logic        data_ok, busy;
  logic [63:0] result;

  int          n_cmp = 0, n_bad = 0;
  logic [63:0] exp_q[$];

  muldiv_iter #(.XLEN(64)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .word(word),
    .a(a), .b(b), .data_ok(data_ok), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] model(input logic [2:0] o, input logic w, input logic [63:0] x, y);
    logic [63:0]        p;
    logic [31:0]        r32;
    logic signed [31:0] xs32, ys32;
    logic signed [63:0] xs, ys;
    xs32 = x[31:0]; ys32 = y[31:0]; xs = x; ys = y;
    if (o == MUL) begin
      p = x * y;
      return w ? sx32(p[31:0]) : p;
    end
    if (w) begin
      if (y[31:0] == 32'h0)
        r32 = (o == DIV || o == DIVU) ? 32'hFFFF_FFFF : x[31:0];
      else if ((o == DIV || o == REM) && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
        r32 = (o == DIV) ? x[31:0] : 32'h0;
      else case (o)
        DIV:     r32 = xs32 / ys32;
        DIVU:    r32 = x[31:0] / y[31:0];
        REM:     r32 = xs32 % ys32;
        default: r32 = x[31:0] % y[31:0];
      endcase
      return sx32(r32);
    end
    if (y == 64'h0) return (o == DIV || o == DIVU) ? 64'hFFFF_FFFF_FFFF_FFFF : x;
    if ((o == DIV || o == REM) && x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF)
      return (o == DIV) ? x : 64'h0;
    case (o)
      DIV:     p = xs / ys;
      DIVU:    p = x / y;
      REM:     p = xs % ys;
      default: p = x % y;
    endcase
    return p;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic w, input logic [63:0] x, y);
    int          n, pos;
    logic        sgn;
    logic [63:0] xe, ye;
    n = w ? 32 : 64;
    pos = 0;
    sgn = (o == DIV || o == REM);
    xe = w ? (sgn ? sx32(x[31:0]) : {32'h0, x[31:0]}) : x;
    ye = w ? (sgn ? sx32(y[31:0]) : {32'h0, y[31:0]}) : y;
    if (o == MUL) begin
`ifdef MULDIV_EARLY_OUT_EN
      for (int i = 0; i < n; i++) if (y[i]) pos = i + 1;
      return (pos + 2 < n + 1) ? pos + 2 : n + 1;
`else
      return n + 1 + pos;
`endif
    end
    if (ye == 64'h0) return 1;
    if (sgn && ye == 64'hFFFF_FFFF_FFFF_FFFF && xe == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))
      return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (sgn && xe[63]) xe = -xe;
    if (sgn && ye[63]) ye = -ye;
    if (xe < ye) return 1;
`endif
    return n + 1;
  endfunction

  // Called at a falling edge; issues one request and checks result, latency and busy cycles.
  task automatic do_op(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y,
                       input int lead, input bit hold, input string name);
    int          lat, cyc, nbusy;
    logic [63:0] want;
    lat = exp_lat(o, w, x, y);
    exp_q.push_back(model(o, w, x, y));
    op = o; word = w; a = x; b = y; valid = 1'b1;
    cyc = 0; nbusy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
      if (!data_ok && cyc > lead) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
    end while (!data_ok && cyc < 300);
    want = exp_q.pop_front();
    n_cmp++;
    if (!data_ok) begin
      n_bad++;
      $display("FAIL %s timeout: no data_ok after %0d cycles, required within %0d", name, cyc, lat + lead);
    end else begin
      if (result !== want) begin
        n_bad++;
        $display("FAIL %s result: got %h, required %h", name, result, want);
      end
      n_cmp++;
      if (cyc !== lat + lead) begin
        n_bad++;
        $display("FAIL %s latency: got %0d, required %0d", name, cyc, lat + lead);
      end
      n_cmp++;
      if (nbusy !== lat - 1) begin
        n_bad++;
        $display("FAIL %s busy_cycles: got %0d, required %0d", name, nbusy, lat - 1);
      end
    end
    if (!hold) begin
      valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (data_ok !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s after_done: data_ok=%b busy=%b, required 0 0", name, data_ok, busy);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (data_ok !== 1'b0 || busy !== 1'b0 || result !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_state: data_ok=%b busy=%b result=%h, required 0 0 0", data_ok, busy, result);
    end
    resetn = 1'b1;
  endtask

  task automatic test_mul();
    do_op(MUL, 1'b0, 64'd7, 64'd6, 0, 0, "mul_7x6");
    do_op(MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 0, 0, "mul_neg");
    do_op(MUL, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 0, 0, "mul_wide");
    do_op(MUL, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 0, 0, "mulw_trunc");
    do_op(MUL, 1'b1, 64'h0000_0003_0000_0007, 64'd9, 0, 0, "mulw_small");
    do_op(MUL, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd5, 0, 0, "mulw_sext");
  endtask

  task automatic test_div();
    do_op(DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 0, 0, "div_m20_3");
    do_op(REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 0, 0, "rem_m20_3");
    do_op(DIVU, 1'b1, 64'd20, 64'd3, 0, 0, "divuw_20_3");
    do_op(DIV,  1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, "div_20_m3");
    do_op(REM,  1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, "rem_20_m3");
    do_op(DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 0, 0, "divu_max");
    do_op(REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 0, 0, "remu_max");
    do_op(DIV,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0, 0, "divw_m7_2");
    do_op(REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0, 0, "remw_m7_2");
    do_op(REMU, 1'b1, 64'h0000_0000_8000_0005, 64'h10, 0, 0, "remuw");
    do_op(DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0, "divuw_sext");
  endtask

  task automatic test_special();
    do_op(DIVU, 1'b0, 64'h1234, 64'h0, 0, 0, "divu_zero");
    do_op(REMU, 1'b0, 64'h1234, 64'h0, 0, 0, "remu_zero");
    do_op(DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "div_ovf");
    do_op(REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "rem_ovf");
    do_op(DIV,  1'b1, 64'h55, 64'h0000_0001_0000_0000, 0, 0, "divw_zero");
    do_op(REM,  1'b1, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000, 0, 0, "remw_zero");
    do_op(DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 0, "divw_ovf");
  endtask

  task automatic test_illegal();
    int seen;
    seen = 0;
    valid = 1'b1; word = 1'b0; a = 64'd9; b = 64'd3;
    for (int o = 5; o < 8; o++) begin
      op = 3'(o);
      repeat (3) begin
        @(negedge clk);
        if (busy || data_ok) seen++;
      end
    end
    valid = 1'b0;
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL illegal_op: %0d active cycles, required 0", seen);
    end
  endtask

  task automatic test_flush();
    int seen;
    do_op(MUL, 1'b0, 64'd11, 64'd13, 0, 0, "flush_pre");
    op = MUL; word = 1'b0; a = 64'h0123_4567_89AB_CDEF; b = 64'hF000_0000_0000_0001; valid = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_busy: busy=%b, required 1", busy);
    end
    valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_idle: busy=%b, required 0", busy);
    end
    seen = 0;
    repeat (80) begin
      if (data_ok || busy) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL flush_quiet: %0d active cycles, required 0", seen);
    end
    n_cmp++;
    if (result !== 64'd143) begin
      n_bad++;
      $display("FAIL flush_hold: result=%h, required %h", result, 64'd143);
    end
    do_op(DIVU, 1'b0, 64'd1000, 64'd7, 0, 0, "flush_next");
  endtask

  task automatic test_reset_mid();
    op = MUL; word = 1'b0; a = 64'd12345; b = 64'h8000_0000_0000_0003; valid = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_busy: busy=%b, required 1", busy);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || data_ok !== 1'b0 || result !== 64'h0) begin
      n_bad++;
      $display("FAIL rst_mid_state: busy=%b data_ok=%b result=%h, required 0 0 0", busy, data_ok, result);
    end
    valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    do_op(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, 0, "rst_recover");
  endtask

  task automatic test_back_to_back();
    do_op(MUL,  1'b0, 64'h1234_5678, 64'h9ABC_DEF0_0000_0001, 0, 1, "b2b_mul");
    do_op(DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 1, 1, "b2b_div");
    do_op(DIVU, 1'b0, 64'h77, 64'h0, 1, 1, "b2b_divz");
    do_op(REMU, 1'b1, 64'h0000_0000_0000_0064, 64'd9, 1, 0, "b2b_remuw");
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_mul();
    test_div();
    test_special();
    test_illegal();
    @(negedge clk);
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
